// File: rtl/ramb4_s4_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// ramb4_s4_port_arbiter_if
// One requester's access port into ramb4_s4_port_arbiter. The arbiter has two
// of these ports (requester 0 and requester 1).
//
// Signals:
//   req    requester -> arbiter  access request; held until granted
//   we     requester -> arbiter  1 = write, 0 = read; qualified by req
//   addr   requester -> arbiter  access address (ADDR_W bits)
//   di     requester -> arbiter  write data (DATA_W bits)
//   gnt    arbiter -> requester  access completes at the clock edge ending
//                                this cycle
//   rvalid arbiter -> requester  read data valid, one cycle after a read grant
//   rdata  arbiter -> requester  read data; shared RAM output
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface ramb4_s4_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] di;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output di,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  di,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/ramb4_s4_port_arbiter.sv
// -----------------------------------------------------------------------------
// ramb4_s4_port_arbiter
// Shares port A of a 1024x4 dual-port block RAM between two requesters with
// round-robin arbitration. Grants and RAM port-A drive are combinational from
// the requests, the round-robin pointer and the FSM state; read data returns
// from the RAM's registered output with a valid strobe one cycle after the
// read grant. RAM port B is not touched.
//
// Ports:
//   CLKA        in   clock (also RAM port-A clock)
//   RSTB        in   synchronous active-high reset
//   port0/1     slave modport of ramb4_s4_port_arbiter_if (req/we/addr/di in,
//               gnt/rvalid/rdata out)
//   busy_o      out  clear sequence in progress (tied 0 when clear disabled)
//   ram_en_o    out  RAM ENA
//   ram_we_o    out  RAM WEA
//   ram_rst_o   out  RAM RSTA, tied 0
//   ram_addr_o  out  RAM ADDRA
//   ram_di_o    out  RAM DIA
//   ram_do_i    in   RAM DOA
//
// Build option: define RAMB4_ARB_CLEAR_EN to enable the post-reset clear
// sequencer, which writes CLEAR_VAL to every address before arbitration
// starts. Without it, arbitration is live in the first cycle after reset.
// -----------------------------------------------------------------------------
module ramb4_s4_port_arbiter #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic                CLKA,
  input  logic                RSTB,
  ramb4_s4_port_arbiter_if.slave port0,
  ramb4_s4_port_arbiter_if.slave port1,
  output logic                busy_o,
  output logic                ram_en_o,
  output logic                ram_we_o,
  output logic                ram_rst_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_di_o,
  input  logic [DATA_W-1:0]   ram_do_i
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

`ifdef RAMB4_ARB_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t state_q, state_d;
  // last_q holds the most recent winner; a tie goes to the other requester.
  logic   last_q, last_d;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;

  logic              gnt0, gnt1;
  logic              busy;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;

`ifdef RAMB4_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`else
  // CLEAR_VAL only matters to the clear sequencer.
  logic unused_clear_val;
  assign unused_clear_val = ^CLEAR_VAL;
`endif

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_q    <= RESET_STATE;
      last_q     <= 1'b1;
      // Clearing the valid flags drops any read granted during reset.
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
`ifdef RAMB4_ARB_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
`ifdef RAMB4_ARB_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    busy       = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_di     = '0;
`ifdef RAMB4_ARB_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif

    case (state_q)
      ST_ARB: begin
        // Requester 0 wins when alone, or on a tie when 1 won last.
        if (port0.req && (!port1.req || last_q)) begin
          gnt0 = 1'b1;
        end else if (port1.req) begin
          gnt1 = 1'b1;
        end

        if (gnt0) begin
          ram_en    = 1'b1;
          ram_we    = port0.we;
          ram_addr  = port0.addr;
          ram_di    = port0.di;
          last_d    = 1'b0;
          rvalid0_d = ~port0.we;
        end else if (gnt1) begin
          ram_en    = 1'b1;
          ram_we    = port1.we;
          ram_addr  = port1.addr;
          ram_di    = port1.di;
          last_d    = 1'b1;
          rvalid1_d = ~port1.we;
        end
      end

`ifdef RAMB4_ARB_CLEAR_EN
      ST_CLEAR: begin
        // Requests are left pending; no grant until the sweep finishes.
        busy       = 1'b1;
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_di     = CLEAR_VAL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) begin
          state_d = ST_ARB;
        end
      end
`endif

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  assign port0.gnt    = gnt0;
  assign port1.gnt    = gnt1;
  assign port0.rvalid = rvalid0_q;
  assign port1.rvalid = rvalid1_q;
  // The RAM output register already holds the granted read's data.
  assign port0.rdata  = ram_do_i;
  assign port1.rdata  = ram_do_i;

  assign busy_o     = busy;
  assign ram_en_o   = ram_en;
  assign ram_we_o   = ram_we;
  assign ram_rst_o  = 1'b0;
  assign ram_addr_o = ram_addr;
  assign ram_di_o   = ram_di;

endmodule
